// File: rtl/reg_file_operand_stage.sv
// reg_file_operand_stage: register file feeding the ALU operands.
// Two registered read ports (Src1/Src2), one write port for the ALU result,
// and a 2-bit {carry, zero} status register captured on Flag_en.
// Register 0 is hardwired to zero. Everything resets asynchronously to 0.
// Optional feature: define REG_BYPASS_EN to forward same-edge write data
// to a read port addressing the register being written.
module reg_file_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Read_en,
    input  logic [ADDR_WIDTH-1:0] Read_addr1,
    input  logic [ADDR_WIDTH-1:0] Read_addr2,
    input  logic                  Write_en,
    input  logic [ADDR_WIDTH-1:0] Write_addr,
    input  logic [DATA_WIDTH-1:0] Write_data,
    input  logic                  Flag_en,
    input  logic                  Alu_zero,
    input  logic                  Alu_carry,
    output logic [DATA_WIDTH-1:0] Read_data1,
    output logic [DATA_WIDTH-1:0] Read_data2,
    output logic [1:0]            Flags
);

    // Register count widened by one bit so it compares cleanly with an address.
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_NUM);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic                  write_ok;
    logic [DATA_WIDTH-1:0] read_next1;
    logic [DATA_WIDTH-1:0] read_next2;

    // Address exists in the file and is not the hardwired zero register.
    function automatic logic addr_writable(input logic [ADDR_WIDTH-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < REG_LIMIT);
    endfunction

    // Stored value at addr; register 0 and out-of-range addresses read as 0.
    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
        if (addr_writable(addr)) begin
            return regs[addr];
        end
        return '0;
    endfunction

    assign write_ok = Write_en && addr_writable(Write_addr);

    // Select the value each read port loads: stored data, or forwarded write data.
    always_comb begin
        read_next1 = read_reg(Read_addr1);
        read_next2 = read_reg(Read_addr2);
`ifdef REG_BYPASS_EN
        if (write_ok && (Write_addr == Read_addr1)) begin
            read_next1 = Write_data;
        end
        if (write_ok && (Write_addr == Read_addr2)) begin
            read_next2 = Write_data;
        end
`endif
    end

    // Register array: cleared on reset, written from the ALU result port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[Write_addr] <= Write_data;
        end
    end

    // Operand outputs: load on Read_en, otherwise hold the last operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Read_data1 <= '0;
            Read_data2 <= '0;
        end else if (Read_en) begin
            Read_data1 <= read_next1;
            Read_data2 <= read_next2;
        end
    end

    // Status register: capture ALU carry/zero only on flagged operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Flags <= 2'b00;
        end else if (Flag_en) begin
            Flags <= {Alu_carry, Alu_zero};
        end
    end

endmodule
